// File: rtl/game_seq.sv
// Game sequencer for a two-player paddle game: serve/play/point/game-over flow,
// score and round keeping, and the tone gate for paddle and point sounds.
module game_seq #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int TONE_FRAMES  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_tick,
    input  logic       i_start_btn,
    input  logic       i_point_left,
    input  logic       i_point_right,
    input  logic       i_paddle_hit,
    output logic [3:0] o_left_score,
    output logic [3:0] o_right_score,
    output logic [1:0] o_round,
    output logic       o_ball_enable,
    output logic       o_ball_reset,
    output logic       o_serve_dir,
    output logic       o_sound_on,
    output logic       o_tone_sel,
    output logic       o_game_over,
    output logic       o_winner
);

    localparam logic [3:0] WIN_S    = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
    localparam logic [3:0] TONE_LD  = 4'(TONE_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    state_t     r_state;
    logic [7:0] r_serve_cnt;
    logic [1:0] r_pts_cnt;
    logic [3:0] r_tone_cnt;

    logic w_in_play;
    logic w_any_point;
    logic w_left_only;
    logic w_right_only;
    logic w_left_room;
    logic w_right_room;
    logic w_score_inc;
    logic w_tone_evt;

    assign w_in_play    = (r_state == S_PLAY);
    assign w_any_point  = i_point_left | i_point_right;
    assign w_left_only  = i_point_left & ~i_point_right;
    assign w_right_only = i_point_right & ~i_point_left;
    assign w_left_room  = (o_left_score < WIN_S);
    assign w_right_room = (o_right_score < WIN_S);
    assign w_score_inc  = w_in_play & ((w_left_only & w_left_room) |
                                       (w_right_only & w_right_room));
    assign w_tone_evt   = w_in_play & (w_any_point | i_paddle_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_serve_cnt   <= '0;
            r_pts_cnt     <= '0;
            o_left_score  <= '0;
            o_right_score <= '0;
            o_round       <= '0;
            o_ball_enable <= 1'b0;
            o_ball_reset  <= 1'b0;
            o_serve_dir   <= 1'b0;
            o_game_over   <= 1'b0;
            o_winner      <= 1'b0;
        end else begin
            // ball_reset is a single-cycle pulse; every entry into SERVE re-arms it
            o_ball_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_left_score  <= '0;
                    o_right_score <= '0;
                    o_round       <= '0;
                    r_pts_cnt     <= '0;
                    if (i_start_btn) begin
                        r_state      <= S_SERVE;
                        r_serve_cnt  <= SERVE_LD;
                        o_ball_reset <= 1'b1;
                        o_serve_dir  <= 1'b1;
                    end
                end

                S_SERVE: begin
                    if (i_frame_tick) begin
                        if (r_serve_cnt <= 8'd1) begin
                            r_state       <= S_PLAY;
                            o_ball_enable <= 1'b1;
                        end else begin
                            r_serve_cnt <= r_serve_cnt - 8'd1;
                        end
                    end
                end

                S_PLAY: begin
                    if (w_any_point) begin
                        r_state       <= S_POINT;
                        o_ball_enable <= 1'b0;
                        if (w_left_only) begin
                            o_serve_dir <= 1'b0;
                            if (w_left_room) o_left_score <= o_left_score + 4'd1;
                        end else if (w_right_only) begin
                            o_serve_dir <= 1'b1;
                            if (w_right_room) o_right_score <= o_right_score + 4'd1;
                        end
                        // every fourth point advances the colour scheme, capped at 3
                        if (w_score_inc) begin
                            r_pts_cnt <= r_pts_cnt + 2'd1;
                            if (r_pts_cnt == 2'd3 && o_round != 2'd3)
                                o_round <= o_round + 2'd1;
                        end
                    end
                end

                S_POINT: begin
                    if (i_frame_tick) begin
                        if (o_left_score == WIN_S) begin
                            r_state     <= S_GAME_OVER;
                            o_game_over <= 1'b1;
                            o_winner    <= 1'b0;
                        end else if (o_right_score == WIN_S) begin
                            r_state     <= S_GAME_OVER;
                            o_game_over <= 1'b1;
                            o_winner    <= 1'b1;
                        end else begin
                            r_state      <= S_SERVE;
                            r_serve_cnt  <= SERVE_LD;
                            o_ball_reset <= 1'b1;
                        end
                    end
                end

                S_GAME_OVER: begin
                    if (i_start_btn) begin
                        r_state       <= S_SERVE;
                        r_serve_cnt   <= SERVE_LD;
                        r_pts_cnt     <= '0;
                        o_left_score  <= '0;
                        o_right_score <= '0;
                        o_round       <= '0;
                        o_ball_reset  <= 1'b1;
                        o_serve_dir   <= 1'b1;
                        o_game_over   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A fresh event always wins over the frame decrement and retargets the tone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_cnt <= '0;
            o_sound_on <= 1'b0;
            o_tone_sel <= 1'b0;
        end else if (w_tone_evt) begin
            r_tone_cnt <= TONE_LD;
            o_sound_on <= 1'b1;
            o_tone_sel <= w_any_point;
        end else if (i_frame_tick && r_tone_cnt != 4'd0) begin
            r_tone_cnt <= r_tone_cnt - 4'd1;
            o_sound_on <= (r_tone_cnt != 4'd1);
        end
    end

endmodule

// File: tb/tb_game_seq.sv
// Self-checking bench for game_seq: directed scenarios plus a randomized run
// compared against a rule-level model of the game flow.
module tb_game_seq;

    localparam int WIN  = 9;
    localparam int SRV  = 60;
    localparam int TONE = 6;

    localparam int MD_IDLE = 0, MD_SERVE = 1, MD_PLAY = 2, MD_POINT = 3, MD_OVER = 4;

    logic clk, rst_n;
    logic frame_tick, start_btn, point_left, point_right, paddle_hit;
    logic [3:0] left_score, right_score;
    logic [1:0] round_idx;
    logic ball_enable, ball_reset, serve_dir, sound_on, tone_sel, game_over, winner;

    logic f_ft, f_st, f_pl, f_pr, f_ph;
    logic [3:0] f_left, f_right;
    logic [1:0] f_round;
    logic f_en, f_brst, f_dir, f_sound, f_sel, f_go, f_win;

    int n_checks = 0;
    int n_errors = 0;

    int   m_mode, m_l, m_r, m_pts, m_serve_ticks, m_tone_left;
    logic m_dir, m_brst, m_sel, m_win;

    game_seq #(.WIN_SCORE(WIN), .SERVE_FRAMES(SRV), .TONE_FRAMES(TONE)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_frame_tick(frame_tick), .i_start_btn(start_btn),
        .i_point_left(point_left), .i_point_right(point_right), .i_paddle_hit(paddle_hit),
        .o_left_score(left_score), .o_right_score(right_score), .o_round(round_idx),
        .o_ball_enable(ball_enable), .o_ball_reset(ball_reset), .o_serve_dir(serve_dir),
        .o_sound_on(sound_on), .o_tone_sel(tone_sel), .o_game_over(game_over),
        .o_winner(winner)
    );

    // Short-serve instance so a PLAY paddle hit can land a few frames after a point tone
    game_seq #(.WIN_SCORE(3), .SERVE_FRAMES(1), .TONE_FRAMES(TONE)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .i_frame_tick(f_ft), .i_start_btn(f_st),
        .i_point_left(f_pl), .i_point_right(f_pr), .i_paddle_hit(f_ph),
        .o_left_score(f_left), .o_right_score(f_right), .o_round(f_round),
        .o_ball_enable(f_en), .o_ball_reset(f_brst), .o_serve_dir(f_dir),
        .o_sound_on(f_sound), .o_tone_sel(f_sel), .o_game_over(f_go),
        .o_winner(f_win)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        m_mode = MD_IDLE; m_l = 0; m_r = 0; m_pts = 0; m_serve_ticks = 0; m_tone_left = 0;
        m_dir = 0; m_brst = 0; m_sel = 0; m_win = 0;
    endfunction

    function automatic int m_round();
        return (m_pts / 4 > 3) ? 3 : m_pts / 4;
    endfunction

    function automatic void model_step(logic ft, logic st, logic pl, logic pr, logic ph);
        bit play = (m_mode == MD_PLAY);
        m_brst = 0;
        if (play && (pl || pr || ph)) begin
            m_tone_left = TONE;
            m_sel = pl || pr;
        end else if (ft && m_tone_left > 0) begin
            m_tone_left--;
        end
        case (m_mode)
            MD_IDLE: if (st) begin
                m_mode = MD_SERVE; m_brst = 1; m_dir = 1; m_serve_ticks = 0;
            end
            MD_SERVE: if (ft) begin
                m_serve_ticks++;
                if (m_serve_ticks == SRV) m_mode = MD_PLAY;
            end
            MD_PLAY: if (pl || pr) begin
                if (pl && !pr) begin
                    m_dir = 0;
                    if (m_l < WIN) begin m_l++; m_pts++; end
                end else if (pr && !pl) begin
                    m_dir = 1;
                    if (m_r < WIN) begin m_r++; m_pts++; end
                end
                m_mode = MD_POINT;
            end
            MD_POINT: if (ft) begin
                if (m_l == WIN) begin m_mode = MD_OVER; m_win = 0; end
                else if (m_r == WIN) begin m_mode = MD_OVER; m_win = 1; end
                else begin m_mode = MD_SERVE; m_brst = 1; m_serve_ticks = 0; end
            end
            MD_OVER: if (st) begin
                m_l = 0; m_r = 0; m_pts = 0; m_brst = 1; m_dir = 1;
                m_mode = MD_SERVE; m_serve_ticks = 0;
            end
            default: m_mode = MD_IDLE;
        endcase
    endfunction

    task automatic step(input logic ft, input logic st, input logic pl, input logic pr,
                        input logic ph);
        frame_tick = ft; start_btn = st; point_left = pl; point_right = pr; paddle_hit = ph;
        @(posedge clk);
        if (rst_n) model_step(ft, st, pl, pr, ph);
        else model_reset();
        #1;
        frame_tick = 0; start_btn = 0; point_left = 0; point_right = 0; paddle_hit = 0;
    endtask

    task automatic fstep(input logic ft, input logic st, input logic pl, input logic pr,
                         input logic ph);
        f_ft = ft; f_st = st; f_pl = pl; f_pr = pr; f_ph = ph;
        @(posedge clk);
        #1;
        f_ft = 0; f_st = 0; f_pl = 0; f_pr = 0; f_ph = 0;
    endtask

    task automatic goto_play();
        int  n = 0;
        logic tog = 1'b0;
        while (m_mode != MD_PLAY && n < 1000) begin
            if (m_mode == MD_IDLE || m_mode == MD_OVER) step(0, 1, 0, 0, 0);
            else begin step(tog, 0, 0, 0, 0); tog = ~tog; end
            n++;
        end
        n_checks++;
        if (ball_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL goto_play: ball_enable=%0b required 1 after %0d cycles", ball_enable, n);
        end
    endtask

    task automatic test_reset();
        logic [18:0] outs;
        rst_n = 1'b0;
        #1;
        outs = {left_score, right_score, round_idx, ball_enable, ball_reset, serve_dir,
                sound_on, tone_sel, game_over, winner};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        step(1, 1, 1, 1, 1);
        outs = {left_score, right_score, round_idx, ball_enable, ball_reset, serve_dir,
                sound_on, tone_sel, game_over, winner};
        n_checks++;
        if (outs !== '0) begin
            n_errors++;
            $display("FAIL reset_held_with_clock: got %h required 0", outs);
        end
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_tone_reload();
        fstep(0, 1, 0, 0, 0);
        fstep(1, 0, 0, 0, 0);
        n_checks++;
        if (f_en !== 1'b1) begin
            n_errors++; $display("FAIL fast_serve: ball_enable=%0b required 1", f_en);
        end
        fstep(0, 0, 1, 0, 0);
        n_checks++;
        if ({f_sound, f_sel} !== 2'b11) begin
            n_errors++; $display("FAIL fast_point_tone: sound,sel=%b required 11", {f_sound, f_sel});
        end
        fstep(1, 0, 0, 0, 0);
        fstep(1, 0, 0, 0, 0);
        fstep(1, 0, 0, 0, 0);
        n_checks++;
        if (f_en !== 1'b1) begin
            n_errors++; $display("FAIL fast_replay: ball_enable=%0b required 1", f_en);
        end
        fstep(1, 0, 0, 0, 1);
        n_checks++;
        if ({f_sound, f_sel} !== 2'b10) begin
            n_errors++; $display("FAIL paddle_reload_sel: sound,sel=%b required 10", {f_sound, f_sel});
        end
        for (int k = 0; k < 5; k++) begin
            fstep(0, 0, 0, 0, 0);
            fstep(1, 0, 0, 0, 0);
        end
        n_checks++;
        if (f_sound !== 1'b1) begin
            n_errors++; $display("FAIL reload_not_decrement: sound_on=%0b required 1 after 5 ticks", f_sound);
        end
        fstep(1, 0, 0, 0, 0);
        n_checks++;
        if (f_sound !== 1'b0) begin
            n_errors++; $display("FAIL reload_expire: sound_on=%0b required 0 after 6 ticks", f_sound);
        end
    endtask

    task automatic test_serve();
        logic early = 1'b0;
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({ball_reset, serve_dir, ball_enable} !== 3'b110) begin
            n_errors++;
            $display("FAIL start_serve: brst,dir,en=%b required 110", {ball_reset, serve_dir, ball_enable});
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ball_reset !== 1'b0) begin
            n_errors++; $display("FAIL ball_reset_single: ball_reset=%0b required 0", ball_reset);
        end
        for (int t = 1; t < SRV; t++) begin
            step(1, 0, 0, 0, 0);
            if (ball_enable !== 1'b0) early = 1'b1;
            step(0, 0, 0, 0, 0);
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_errors++; $display("FAIL serve_early: ball_enable rose before tick %0d", SRV);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (ball_enable !== 1'b1) begin
            n_errors++; $display("FAIL serve_to_play: ball_enable=%0b required 1", ball_enable);
        end
    endtask

    task automatic test_point_left();
        step(0, 0, 1, 0, 0);
        n_checks++;
        if ({left_score, right_score, serve_dir, sound_on, tone_sel, ball_enable} !== 12'h1_0_6) begin
            n_errors++;
            $display("FAIL point_left: L=%0d R=%0d dir=%0b snd=%0b sel=%0b en=%0b required 1 0 0 1 1 0",
                     left_score, right_score, serve_dir, sound_on, tone_sel, ball_enable);
        end
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ball_reset !== 1'b0) begin
            n_errors++; $display("FAIL point_wait: ball_reset=%0b required 0", ball_reset);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (ball_reset !== 1'b1) begin
            n_errors++; $display("FAIL point_reserve: ball_reset=%0b required 1", ball_reset);
        end
        for (int k = 2; k <= 5; k++) begin
            step(0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        n_checks++;
        if (sound_on !== 1'b1) begin
            n_errors++; $display("FAIL tone_5: sound_on=%0b required 1", sound_on);
        end
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (sound_on !== 1'b0) begin
            n_errors++; $display("FAIL tone_6: sound_on=%0b required 0", sound_on);
        end
    endtask

    task automatic test_simultaneous();
        goto_play();
        step(0, 0, 1, 1, 0);
        n_checks++;
        if ({left_score, right_score, ball_enable, serve_dir} !== 10'b0001_0000_00) begin
            n_errors++;
            $display("FAIL both_points: L=%0d R=%0d en=%0b dir=%0b required 1 0 0 0",
                     left_score, right_score, ball_enable, serve_dir);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if ({ball_reset, game_over, left_score} !== 6'b10_0001) begin
            n_errors++;
            $display("FAIL both_to_serve: brst=%0b go=%0b L=%0d required 1 0 1",
                     ball_reset, game_over, left_score);
        end
    endtask

    task automatic test_reset_mid_play();
        logic [18:0] outs;
        logic bad = 1'b0;
        goto_play();
        step(0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        outs = {left_score, right_score, round_idx, ball_enable, ball_reset, serve_dir,
                sound_on, tone_sel, game_over, winner};
        n_checks++;
        if (outs !== '0) begin
            n_errors++; $display("FAIL async_reset_mid_play: got %h required 0", outs);
        end
        step(0, 1, 0, 0, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(k[0], 0, 0, 0, 0);
            if (ball_reset !== 1'b0 || ball_enable !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++; $display("FAIL idle_after_reset: ball_reset/enable went high without start");
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({ball_reset, serve_dir} !== 2'b11) begin
            n_errors++; $display("FAIL restart: brst,dir=%b required 11", {ball_reset, serve_dir});
        end
    endtask

    task automatic test_game_over();
        for (int p = 1; p <= 8; p++) begin
            goto_play();
            step(0, 0, 1, 0, 0);
            if (p == 4) begin
                n_checks++;
                if (round_idx !== 2'd1) begin
                    n_errors++; $display("FAIL round_after_4: round=%0d required 1", round_idx);
                end
            end
        end
        n_checks++;
        if ({left_score, right_score, round_idx} !== 10'b1000_0000_10) begin
            n_errors++;
            $display("FAIL score_8_0: L=%0d R=%0d round=%0d required 8 0 2", left_score, right_score, round_idx);
        end
        goto_play();
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (left_score !== 4'd9) begin
            n_errors++; $display("FAIL score_9: L=%0d required 9", left_score);
        end
        step(1, 0, 0, 0, 0);
        n_checks++;
        if ({game_over, winner, ball_reset, ball_enable} !== 4'b1000) begin
            n_errors++;
            $display("FAIL game_over_left: go,win,brst,en=%b required 1000",
                     {game_over, winner, ball_reset, ball_enable});
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 1);
        n_checks++;
        if ({left_score, right_score, game_over} !== 9'b1001_0000_1) begin
            n_errors++;
            $display("FAIL over_ignores_points: L=%0d R=%0d go=%0b required 9 0 1", left_score, right_score, game_over);
        end
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({left_score, right_score, round_idx, game_over, ball_reset, serve_dir} !== 13'b0000_0000_00_011) begin
            n_errors++;
            $display("FAIL restart_clear: L=%0d R=%0d round=%0d go=%0b brst=%0b dir=%0b required 0 0 0 0 1 1",
                     left_score, right_score, round_idx, game_over, ball_reset, serve_dir);
        end
    endtask

    task automatic test_round_saturate();
        for (int p = 0; p < 16; p++) begin
            goto_play();
            if (p % 2 == 0) step(0, 0, 1, 0, 0);
            else step(0, 0, 0, 1, 0);
            if (p == 11) begin
                n_checks++;
                if (round_idx !== 2'd3) begin
                    n_errors++; $display("FAIL round_after_12: round=%0d required 3", round_idx);
                end
            end
        end
        n_checks++;
        if ({left_score, right_score, round_idx} !== 10'b1000_1000_11) begin
            n_errors++;
            $display("FAIL round_after_16: L=%0d R=%0d round=%0d required 8 8 3", left_score, right_score, round_idx);
        end
        goto_play();
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if ({right_score, round_idx, game_over, winner} !== 8'b1001_11_1_1) begin
            n_errors++;
            $display("FAIL game_over_right: R=%0d round=%0d go=%0b win=%0b required 9 3 1 1",
                     right_score, round_idx, game_over, winner);
        end
    endtask

    task automatic test_random();
        logic prev_brst = 1'b0;
        logic ft, st, pl, pr, ph;
        for (int i = 0; i < 4000; i++) begin
            ft = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 29) == 0);
            pl = ($urandom_range(0, 11) == 0);
            pr = ($urandom_range(0, 11) == 0);
            ph = ($urandom_range(0, 7) == 0);
            if (i == 2000) rst_n = 1'b0;
            if (i == 2003) rst_n = 1'b1;
            step(ft, st, pl, pr, ph);
            n_checks++;
            if (left_score !== 4'(m_l)) begin
                n_errors++; $display("FAIL rnd_left cyc %0d: got %0d required %0d", i, left_score, m_l);
            end
            n_checks++;
            if (right_score !== 4'(m_r)) begin
                n_errors++; $display("FAIL rnd_right cyc %0d: got %0d required %0d", i, right_score, m_r);
            end
            n_checks++;
            if (round_idx !== 2'(m_round())) begin
                n_errors++; $display("FAIL rnd_round cyc %0d: got %0d required %0d", i, round_idx, m_round());
            end
            n_checks++;
            if (ball_enable !== (m_mode == MD_PLAY)) begin
                n_errors++; $display("FAIL rnd_enable cyc %0d: got %0b required %0b", i, ball_enable, m_mode == MD_PLAY);
            end
            n_checks++;
            if (ball_reset !== m_brst || (ball_reset && prev_brst)) begin
                n_errors++; $display("FAIL rnd_ball_reset cyc %0d: got %0b required %0b (prev %0b)", i, ball_reset, m_brst, prev_brst);
            end
            n_checks++;
            if (serve_dir !== m_dir) begin
                n_errors++; $display("FAIL rnd_dir cyc %0d: got %0b required %0b", i, serve_dir, m_dir);
            end
            n_checks++;
            if (sound_on !== (m_tone_left > 0)) begin
                n_errors++; $display("FAIL rnd_sound cyc %0d: got %0b required %0b", i, sound_on, m_tone_left > 0);
            end
            n_checks++;
            if (tone_sel !== m_sel) begin
                n_errors++; $display("FAIL rnd_tone_sel cyc %0d: got %0b required %0b", i, tone_sel, m_sel);
            end
            n_checks++;
            if (game_over !== (m_mode == MD_OVER)) begin
                n_errors++; $display("FAIL rnd_game_over cyc %0d: got %0b required %0b", i, game_over, m_mode == MD_OVER);
            end
            if (m_mode == MD_OVER) begin
                n_checks++;
                if (winner !== m_win) begin
                    n_errors++; $display("FAIL rnd_winner cyc %0d: got %0b required %0b", i, winner, m_win);
                end
            end
            prev_brst = ball_reset;
        end
    endtask

    initial begin
        frame_tick = 0; start_btn = 0; point_left = 0; point_right = 0; paddle_hit = 0;
        f_ft = 0; f_st = 0; f_pl = 0; f_pr = 0; f_ph = 0;
        model_reset();
        test_reset();
        test_tone_reload();
        test_serve();
        test_point_left();
        test_simultaneous();
        test_reset_mid_play();
        test_game_over();
        test_round_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/game_seq.md
GAME_SEQ -- requirements
Module: game_seq

Interface
REQ-001 The module SHALL have parameter WIN_SCORE, default 9, meaning the score (1..15) that ends a game.
REQ-002 The module SHALL have parameter SERVE_FRAMES, default 60, meaning the frame_tick count (1..255) spent in SERVE before play.
REQ-003 The module SHALL have parameter TONE_FRAMES, default 6, meaning the frame_tick count (1..15) that sound_on stays high per event.
REQ-004 clk  input  1  system pixel clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 start_btn  input  1  level, synchronised upstream; starts or restarts a game.
REQ-008 point_left  input  1  one-cycle pulse from ball logic: left player scored.
REQ-009 point_right  input  1  one-cycle pulse from ball logic: right player scored.
REQ-010 paddle_hit  input  1  one-cycle pulse from ball logic: ball struck a paddle.
REQ-011 left_score  output  4  left player score.
REQ-012 right_score  output  4  right player score.
REQ-013 round  output  2  round index driving the display colour scheme.
REQ-014 ball_enable  output  1  high only while the ball may move (PLAY).
REQ-015 ball_reset  output  1  one-cycle pulse: recentre the ball.
REQ-016 serve_dir  output  1  initial ball direction; 0 = toward left, 1 = toward right.
REQ-017 sound_on  output  1  gates the square-wave tone generator.
REQ-018 tone_sel  output  1  0 = paddle tone, 1 = point tone.
REQ-019 game_over  output  1  high in GAME_OVER state.
REQ-020 winner  output  1  0 = left won, 1 = right won; valid while game_over is high.

Function
REQ-021 The FSM SHALL have states IDLE, SERVE, PLAY, POINT and GAME_OVER, with all outputs registered.
REQ-022 IDLE: scores = 0, round = 0; when start_btn = 1, go to SERVE, pulse ball_reset and set serve_dir = 1.
REQ-023 SERVE: ball_enable = 0; count frame_tick pulses; on the SERVE_FRAMES-th tick, go to PLAY on the next cycle.
REQ-024 PLAY: ball_enable = 1; point_left alone increments left_score, sets serve_dir = 0 and goes to POINT.
REQ-025 PLAY: point_right alone increments right_score, sets serve_dir = 1 and goes to POINT.
REQ-026 PLAY: point_left and point_right in the same cycle change no score, keep serve_dir and go to POINT.
REQ-027 Every score increment SHALL increment a 2-bit points counter; when the counter wraps to 0, round increments, saturating at 3.
REQ-028 POINT: ball_enable = 0 and the FSM waits for the next frame_tick.
REQ-029 On that frame_tick, if either score equals WIN_SCORE, go to GAME_OVER with winner set to that side.
REQ-030 On that frame_tick, otherwise pulse ball_reset and go to SERVE.
REQ-031 GAME_OVER: game_over = 1 and scores hold; when start_btn = 1, clear scores, round and the points counter, pulse ball_reset, set serve_dir = 1 and go to SERVE.
REQ-032 Point and paddle_hit pulses outside PLAY SHALL be ignored.
REQ-033 A score SHALL never exceed WIN_SCORE.
REQ-034 Score, round and state updates SHALL appear one cycle after the causing input pulse.
REQ-035 A PLAY point event or paddle_hit SHALL load the tone counter with TONE_FRAMES and set sound_on = 1 next cycle.
REQ-036 tone_sel SHALL be 1 for a point event and 0 for paddle_hit; a point wins if both occur in the same cycle.
REQ-037 The tone counter SHALL decrement on each frame_tick; sound_on clears when it reaches 0.
REQ-038 A new tone event SHALL reload the counter and override tone_sel.
REQ-039 A frame_tick coincident with a tone event SHALL apply the reload, not the decrement.
REQ-040 ball_reset SHALL never be high for two consecutive cycles.

Reset
REQ-041 While rst_n = 0, state = IDLE and every output = 0, regardless of clk.
REQ-042 The SERVE and tone counters SHALL be cleared by reset.
REQ-043 Reset deassertion mid-game SHALL resume in IDLE with no ball_reset pulse until start_btn.

Verification
REQ-044 Reset, then start_btn = 1 -> ball_reset pulses once, serve_dir = 1, ball_enable = 0 for 60 frame_ticks, then 1.
REQ-045 In PLAY, point_left pulse -> left_score 0->1 next cycle, serve_dir = 0, sound_on = 1, tone_sel = 1; sound_on low after 6 frame_ticks; ball_reset at next frame_tick.
REQ-046 In PLAY, point_left and point_right in the same cycle -> both scores unchanged, FSM goes to POINT, then SERVE.
REQ-047 Score 8-0, point_left -> left_score = 9, next frame_tick gives game_over = 1, winner = 0; further point pulses are ignored; start_btn clears to 0-0 in SERVE.
REQ-048 4 points scored -> round 0->1; after 16 points round stays at 3.
REQ-049 paddle_hit 3 frames after a point tone -> tone_sel = 0, tone counter reloads to 6; rst_n low mid-PLAY -> all outputs 0 immediately.
